// File: rtl/ftrace_event_sched.sv
// ftrace_event_sched: classifies retired calls/returns, tracks call depth and
// queues trace events for a valid/ready consumer, draining on halt.
module ftrace_event_sched #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int OW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_inst,
  input  logic [31:0]                commit_pc,
  input  logic [31:0]                commit_dnpc,
  input  logic                       flush,
  input  logic                       halt,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [1:0]                 ev_kind,
  output logic [31:0]                ev_pc,
  output logic [31:0]                ev_target,
  output logic [DW-1:0]              ev_depth,
  output logic [OW-1:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, FIN} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] depth, ev_dep, depth_nxt;
  logic [LW-1:0] level_nxt;
  logic [1:0]    kind_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   tgt_q  [DEPTH];
  logic [DW-1:0] dep_q  [DEPTH];
  logic jal_op, jalr_op, is_call, is_ret, ev, full, deq, enq, drop;
  assign jal_op  = commit_inst[6:0] == 7'b1101111;
  assign jalr_op = commit_inst[6:0] == 7'b1100111 && commit_inst[14:12] == 3'b000;
  assign is_call = commit_valid && (jal_op || jalr_op) && commit_inst[11:7] == 5'd1;
  assign is_ret  = commit_valid && !is_call && jalr_op && commit_inst[11:7] == 5'd0 &&
                   commit_inst[31:20] == 12'd0;
  assign ev      = (is_call || is_ret) && state == RUN && !flush;
  assign full    = level == LW'(DEPTH);
  assign deq     = ev_valid && ev_ready && !flush;
  assign enq     = ev && (!full || deq);
  assign drop    = ev && full && !deq;
  // Returns record the post-decrement depth so matched pairs share a level.
  assign ev_dep    = is_call ? depth : (depth == '0 ? depth : depth - 1'b1);
  assign depth_nxt = is_call ? (depth == '1 ? depth : depth + 1'b1) : ev_dep;
  assign level_nxt = level + LW'(enq) - LW'(deq);
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = halt ? DRAIN : RUN;
      DRAIN:   state_nxt = level_nxt == '0 ? FIN : DRAIN;
      default: state_nxt = FIN;
    endcase
    if (flush) state_nxt = RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RUN;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      depth    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      state <= RUN;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      depth <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      if (ev) depth <= depth_nxt;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (enq) begin
      kind_q[wptr] <= is_call ? 2'b01 : 2'b10;
      pc_q[wptr]   <= commit_pc;
      tgt_q[wptr]  <= commit_dnpc;
      dep_q[wptr]  <= ev_dep;
    end
  assign ev_valid  = level != '0;
  assign ev_kind   = ev_valid ? kind_q[rptr] : 2'b00;
  assign ev_pc     = ev_valid ? pc_q[rptr] : 32'd0;
  assign ev_target = ev_valid ? tgt_q[rptr] : 32'd0;
  assign ev_depth  = ev_valid ? dep_q[rptr] : '0;
  assign done      = state == FIN;
endmodule

// File: doc/ftrace_event_sched.md
Name: ftrace_event_sched

Overview:
- Sequences function-trace reporting for the NPC core.
- Classifies each committed instruction as call or return and tracks a hardware call depth.
- Buffers events in a small FIFO and drains them to the simulation-side consumer over a valid/ready handshake, so bursts of calls never stall commit.
- On program halt, the block drains any pending events and then signals completion.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DW, 8, width of call-depth counter and ev_depth.
- OW, 16, width of drop counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_inst  in  32  retired instruction word.
- commit_pc  in  32  PC of retired instruction.
- commit_dnpc  in  32  next PC after the retired instruction.
- flush  in  1  synchronous clear of FIFO and depth.
- halt  in  1  single-cycle pulse at program end (ebreak).
- ev_valid  out  1  head event available.
- ev_ready  in  1  consumer accepts head event.
- ev_kind  out  2  01 = call, 10 = return, 00 when ev_valid is 0.
- ev_pc  out  32  source PC of head event.
- ev_target  out  32  dnpc of head event.
- ev_depth  out  DW  nesting level of head event.
- drop_cnt  out  OW  events lost to a full FIFO.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- done  out  1  drain complete after halt.

Behaviour:
- Reset (rst_n low, async): FIFO empty, depth 0, drop_cnt 0, state RUN, ev_valid 0, ev_kind 00, ev_pc/ev_target/ev_depth 0, level 0, done 0.
- Classification (combinational on commit_inst, qualified by commit_valid):
  - call: opcode 1101111 with rd=1, or opcode 1100111 with funct3=000 and rd=1.
  - return: opcode 1100111, funct3=000, rd=0, imm[11:0]=0. This includes 32'h00008067.
  - Call is checked first. Anything else is no event.
- Depth:
  - Call event records the current depth, then depth increments, saturating at 2^DW-1.
  - Return: depth decrements, saturating at 0, and the event records the post-decrement value. A matched call/return pair therefore carries an equal ev_depth.
  - Depth updates even if the event is dropped.
- FIFO:
  - Show-ahead: head fields drive the outputs combinationally from registered storage; ev_valid = (level != 0).
  - Dequeue when ev_valid and ev_ready. Enqueue when a classified event occurs in state RUN.
  - Enqueue latency: an event committed in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
  - Full and dequeue in the same cycle: the enqueue is accepted and level is unchanged.
  - Full with no dequeue: the event is dropped and drop_cnt increments, saturating at 2^OW-1.
  - Empty: ev_ready is ignored.
  - Pointers wrap modulo DEPTH.
- State machine:
  - RUN: accept events. halt moves to DRAIN in the next cycle; an event committed in the same cycle as halt is still enqueued.
  - DRAIN: classified commits are ignored (no enqueue, no depth change, no drop count). When level reaches 0, move to DONE.
  - DONE: done=1, held. Events are ignored. Only reset or flush leaves DONE.
- flush (highest priority after reset):
  - Next cycle: level 0, depth 0, state RUN, done 0.
  - drop_cnt is preserved.
  - A commit or dequeue in the same cycle as flush has no effect.
- Reset asserted mid-drain aborts the drain immediately; all state returns to reset values.

Test Plan:
- Single call then return: commit 0x00C000EF (jal ra) at pc 0x80000000, dnpc 0x8000000C; then 0x00008067 at pc 0x80000010, dnpc 0x80000004; ev_ready=1.
  -> call event (kind 01, depth 0, target 0x8000000C), then return event (kind 10, depth 0, target 0x80000004); level returns to 0.
- Backpressure overflow: ev_ready=0, 10 consecutive calls with DEPTH=8.
  -> level=8, drop_cnt=2, depth=10. Releasing ready yields depths 0..7 in order.
- Full with simultaneous dequeue: level 8, ev_ready=1, one call committed.
  -> accepted, level stays 8, drop_cnt unchanged.
- Non-event filter: jal x0, jalr rd=0 with imm=4, and addi committed.
  -> no events, depth unchanged. jalr x0, 0(t0) (0x00028067) -> return event.
- Halt drain: 3 events queued, ev_ready=0, pulse halt, commit one more call, then ev_ready=1.
  -> the extra call is ignored; done asserts the cycle after the 3rd dequeue.
- Flush and reset mid-DRAIN: flush -> level 0, depth 0, state RUN, drop_cnt preserved. Repeat with rst_n low -> all outputs at reset values asynchronously.
